// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions: state encodings, signal polarity and direction
// constants, and the counter-width helper used by the timeout logic.
package bus_master_if_pkg;

  localparam int BUS_IF_STATE_BUS = 2;

  localparam logic [BUS_IF_STATE_BUS-1:0] BUS_IF_STATE_IDLE   = 2'd0;
  localparam logic [BUS_IF_STATE_BUS-1:0] BUS_IF_STATE_REQ    = 2'd1;
  localparam logic [BUS_IF_STATE_BUS-1:0] BUS_IF_STATE_ACCESS = 2'd2;
  localparam logic [BUS_IF_STATE_BUS-1:0] BUS_IF_STATE_STALL  = 2'd3;

  typedef enum logic [BUS_IF_STATE_BUS-1:0] {
    ST_IDLE   = BUS_IF_STATE_IDLE,
    ST_REQ    = BUS_IF_STATE_REQ,
    ST_ACCESS = BUS_IF_STATE_ACCESS,
    ST_STALL  = BUS_IF_STATE_STALL
  } bus_if_state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Bits needed to count 0..limit-1 (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Shared-bus signal bundle between one bus master and the arbiter/slaves.
interface bus_master_if_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_if_timeout_cnt.sv
// Clearable, saturating wait counter with a terminal-count flag at LIMIT-1.
// LIMIT=0 disables the flag entirely.
module bus_master_if_timeout_cnt
  import bus_master_if_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);
  localparam int CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (inc && !tc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (LIMIT != 0) && (count_reg == LAST);
endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface: converts a single-cycle core request into the
// request / grant / address-strobe / ready sequence, with stall, flush and timeout.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              busy,
  output logic              bus_err,
  bus_master_if_if.master   bus
);
  bus_if_state_e     state_reg;
  logic              req_reg;
  logic              as_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              err_reg;
  logic              timeout_tc;

  bus_master_if_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clear(state_reg == ST_REQ),
    .inc  ((state_reg == ST_ACCESS) && (bus.bus_rdy_ == DISABLE_)),
    .tc   (timeout_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      req_reg     <= DISABLE_;
      as_reg      <= DISABLE_;
      rw_reg      <= READ;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      rd_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      as_reg  <= DISABLE_;
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (core_req && !flush) begin
            addr_reg    <= core_addr;
            rw_reg      <= core_rw;
            wr_data_reg <= core_wr_data;
            req_reg     <= ENABLE_;
            state_reg   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A grant on the same edge as a flush wins: the access is already committed.
          if (bus.bus_grnt_ == ENABLE_) begin
            as_reg    <= ENABLE_;
            state_reg <= ST_ACCESS;
          end else if (flush) begin
            req_reg   <= DISABLE_;
            state_reg <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (bus.bus_rdy_ == ENABLE_) begin
            if (rw_reg == READ) rd_data_reg <= bus.bus_rd_data;
            req_reg   <= DISABLE_;
            state_reg <= stall ? ST_STALL : ST_IDLE;
          end else if (timeout_tc) begin
            req_reg     <= DISABLE_;
            rd_data_reg <= '0;
            err_reg     <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!stall) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = ((state_reg == ST_IDLE) && core_req && !flush)
              || (state_reg == ST_REQ) || (state_reg == ST_ACCESS);

  assign core_rd_data    = rd_data_reg;
  assign bus_err         = err_reg;
  assign bus.bus_req_    = req_reg;
  assign bus.bus_as_     = as_reg;
  assign bus.bus_rw      = rw_reg;
  assign bus.bus_addr    = addr_reg;
  assign bus.bus_wr_data = wr_data_reg;
endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: bench drives arbiter/slave signals,
// completions are checked against a queue of expected results.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              core_req;
  logic              core_rw;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [DATA_W-1:0] core_rd_data;
  logic              busy;
  logic              bus_err;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .core_req    (core_req),
    .core_rw     (core_rw),
    .core_addr   (core_addr),
    .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data),
    .busy        (busy),
    .bus_err     (bus_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] rd, input logic err);
    sb.push_back({rd, err});
  endtask

  // Present a one-cycle core request; afterwards the bus request must be low.
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    core_req     = 1'b1;
    core_rw      = rw;
    core_addr    = a;
    core_wr_data = d;
    tick();
    core_req = 1'b0;
    chk("issue_req_low", 64'(bus.bus_req_), 64'(0));
    chk("issue_addr", 64'(bus.bus_addr), 64'(a));
    chk("issue_rw", 64'(bus.bus_rw), 64'(rw));
  endtask

  // Called on the cycle after the completing edge.
  task automatic complete(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rd_data"}, 64'(core_rd_data), 64'(e.rd));
      chk({tag, "_bus_err"}, 64'(bus_err), 64'(e.err));
      chk({tag, "_req_released"}, 64'(bus.bus_req_), 64'(1));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; core_req = 1'b0; core_rw = READ;
    core_addr = '0; core_wr_data = '0;
    bus.bus_grnt_ = DISABLE_; bus.bus_rdy_ = DISABLE_; bus.bus_rd_data = '0;
    tick(); tick();
    chk("rst_req_", 64'(bus.bus_req_), 64'(1));
    chk("rst_as_", 64'(bus.bus_as_), 64'(1));
    chk("rst_rw", 64'(bus.bus_rw), 64'(1));
    chk("rst_addr", 64'(bus.bus_addr), 64'(0));
    chk("rst_wr_data", 64'(bus.bus_wr_data), 64'(0));
    chk("rst_rd_data", 64'(core_rd_data), 64'(0));
    chk("rst_err", 64'(bus_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    tick();

    // Read, immediate grant, ready one cycle after the strobe.
    push(32'hDEAD_BEEF, 1'b0);
    issue(READ, 30'h100, 32'h0);
    chk("rd_c1_as_high", 64'(bus.bus_as_), 64'(1));
    chk("rd_c1_busy", 64'(busy), 64'(1));
    bus.bus_grnt_ = ENABLE_;
    tick();
    chk("rd_c2_as_low", 64'(bus.bus_as_), 64'(0));
    tick();
    chk("rd_c3_as_high", 64'(bus.bus_as_), 64'(1));
    chk("rd_c3_req_low", 64'(bus.bus_req_), 64'(0));
    bus.bus_rdy_ = ENABLE_; bus.bus_rd_data = 32'hDEAD_BEEF;
    tick();
    complete("rd");
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_; bus.bus_rd_data = '0;
    tick();

    // Write with grant delayed 5 cycles; read data must not change.
    push(32'hDEAD_BEEF, 1'b0);
    issue(WRITE, 30'h200, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk("wr_wait_as_high", 64'(bus.bus_as_), 64'(1));
      chk("wr_wait_wdata", 64'(bus.bus_wr_data), 64'h1234_5678);
      tick();
    end
    bus.bus_grnt_ = ENABLE_;
    tick();
    chk("wr_as_after_grant", 64'(bus.bus_as_), 64'(0));
    chk("wr_rw", 64'(bus.bus_rw), 64'(0));
    bus.bus_rdy_ = ENABLE_; bus.bus_rd_data = 32'h5A5A_5A5A;
    tick();
    complete("wr");
    chk("wr_wdata_hold", 64'(bus.bus_wr_data), 64'h1234_5678);
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_;
    tick();

    // Flush in REQ without grant cancels the access.
    issue(READ, 30'h300, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_released", 64'(bus.bus_req_), 64'(1));
    chk("fl_as_high", 64'(bus.bus_as_), 64'(1));
    chk("fl_busy", 64'(busy), 64'(0));
    tick();
    chk("fl_no_as", 64'(bus.bus_as_), 64'(1));
    chk("fl_still_idle", 64'(bus.bus_req_), 64'(1));

    // Flush and grant on the same edge: grant wins, flush cannot abort ACCESS.
    push(32'hCAFE_0001, 1'b0);
    issue(READ, 30'h304, 32'h0);
    flush = 1'b1; bus.bus_grnt_ = ENABLE_;
    tick();
    chk("flg_as_low", 64'(bus.bus_as_), 64'(0));
    tick();
    chk("flg_access_held", 64'(bus.bus_req_), 64'(0));
    flush = 1'b0; bus.bus_rdy_ = ENABLE_; bus.bus_rd_data = 32'hCAFE_0001;
    tick();
    complete("flg");
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_;
    tick();

    // Stall at ready: data held, next request waits for stall release.
    push(32'h5555_AAAA, 1'b0);
    issue(READ, 30'h400, 32'h0);
    bus.bus_grnt_ = ENABLE_;
    tick();
    bus.bus_rdy_ = ENABLE_; bus.bus_rd_data = 32'h5555_AAAA; stall = 1'b1;
    tick();
    complete("st");
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_; bus.bus_rd_data = 32'h0BAD_F00D;
    core_req = 1'b1; core_rw = READ; core_addr = 30'h500;
    push(32'h0BAD_F00D, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("st_busy_low", 64'(busy), 64'(0));
      tick();
      chk("st_hold_data", 64'(core_rd_data), 64'h5555_AAAA);
      chk("st_not_accepted", 64'(bus.bus_req_), 64'(1));
    end
    stall = 1'b0;
    tick();
    chk("st_idle_not_yet", 64'(bus.bus_req_), 64'(1));
    chk("st_idle_busy", 64'(busy), 64'(1));
    tick();
    core_req = 1'b0;
    chk("st_next_accepted", 64'(bus.bus_req_), 64'(0));
    chk("st_next_addr", 64'(bus.bus_addr), 64'(30'h500));
    bus.bus_grnt_ = ENABLE_; bus.bus_rdy_ = ENABLE_;
    tick();
    chk("st_next_as_low", 64'(bus.bus_as_), 64'(0));
    chk("st_next_req_held", 64'(bus.bus_req_), 64'(0));
    tick();
    complete("st_next");
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_;
    tick();

    // Slave never ready: abort after TIMEOUT access cycles.
    push(32'h0, 1'b1);
    issue(READ, 30'h600, 32'h0);
    bus.bus_grnt_ = ENABLE_; bus.bus_rd_data = 32'h1111_1111;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("to_no_err_yet", 64'(bus_err), 64'(0));
      chk("to_req_held", 64'(bus.bus_req_), 64'(0));
    end
    tick();
    complete("to");
    tick();
    chk("to_err_one_cycle", 64'(bus_err), 64'(0));
    bus.bus_grnt_ = DISABLE_;

    // Ready on the last allowed cycle wins over the timeout.
    push(32'h7777_8888, 1'b0);
    issue(READ, 30'h604, 32'h0);
    bus.bus_grnt_ = ENABLE_;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.bus_rdy_ = ENABLE_; bus.bus_rd_data = 32'h7777_8888;
    tick();
    complete("to_rdy");
    bus.bus_rdy_ = DISABLE_; bus.bus_grnt_ = DISABLE_;
    tick();
    chk("to_rdy_no_err", 64'(bus_err), 64'(0));

    // Synchronous reset in the middle of an access.
    issue(WRITE, 30'h700, 32'hFFFF_0000);
    bus.bus_grnt_ = ENABLE_;
    tick();
    chk("rs_in_access", 64'(bus.bus_req_), 64'(0));
    reset = 1'b1;
    tick();
    chk("rs_req_", 64'(bus.bus_req_), 64'(1));
    chk("rs_as_", 64'(bus.bus_as_), 64'(1));
    chk("rs_busy", 64'(busy), 64'(0));
    chk("rs_err", 64'(bus_err), 64'(0));
    chk("rs_rd_data", 64'(core_rd_data), 64'(0));
    chk("rs_addr", 64'(bus.bus_addr), 64'(0));
    reset = 1'b0; bus.bus_grnt_ = DISABLE_;
    tick();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side bus interface placed directly upstream of the 4-master round-robin bus arbiter.
- Turns a single-cycle core access request (fetch or load/store unit) into the shared-bus sequence: request, wait for grant, address strobe, wait for ready, return data.
- Handles pipeline stall and flush, and aborts accesses whose slave never responds.
- One instance per bus master (m0..m3).

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in ACCESS waiting for bus_rdy_; 0 = no timeout

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stall  in  1  pipeline stall; hold returned data
flush  in  1  pipeline flush; cancel access not yet on bus
core_req  in  1  access request, sampled in IDLE
core_rw  in  1  1 = read, 0 = write
core_addr  in  ADDR_W  word address
core_wr_data  in  DATA_W  write data
core_rd_data  out  DATA_W  read data, registered
busy  out  1  access in progress; core must stall
bus_err  out  1  one-cycle pulse on timeout abort
bus_req_  out  1  bus request to arbiter, active-low
bus_grnt_  in  1  grant from arbiter, active-low
bus_addr  out  ADDR_W  bus address, registered
bus_as_  out  1  address strobe, active-low, one cycle
bus_rw  out  1  bus read/write
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  slave read data
bus_rdy_  in  1  slave ready, active-low

Behaviour:
- Reset values: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1 (read), bus_addr=0, bus_wr_data=0, core_rd_data=0, bus_err=0, timeout counter=0.
- Reset mid-access returns to IDLE on the next edge with all bus outputs deasserted. No completion and no bus_err is reported.
- States: IDLE, REQ, ACCESS, STALL. Encoding goes in the shared header.
- IDLE: on an edge with core_req=1 and flush=0, latch core_addr/core_rw/core_wr_data into bus_addr/bus_rw/bus_wr_data, set bus_req_<=0, go to REQ. If flush=1, ignore core_req.
- REQ: bus_req_ stays low.
  - grnt_=0 at an edge: bus_as_<=0 for exactly one cycle, clear the counter, go to ACCESS.
  - flush=1 with grnt_=1: bus_req_<=1, go to IDLE (access cancelled).
  - flush=1 with grnt_=0 at the same edge: grant wins and the access proceeds.
- ACCESS: bus_as_<=1 after its single cycle. bus_req_ stays low, which holds the grant. bus_rdy_ is honoured in any ACCESS cycle, including the cycle bus_as_ is low.
  - rdy_=0 at an edge: core_rd_data<=bus_rd_data on reads (unchanged on writes), bus_req_<=1, go to STALL if stall=1, else IDLE.
  - flush does not abort an access already on the bus.
  - TIMEOUT!=0: the counter increments each ACCESS cycle without ready. When counter==TIMEOUT-1 and rdy_=1: bus_req_<=1, core_rd_data<=0, bus_err<=1 for one cycle, go to IDLE. rdy_ arriving on that same edge takes priority, with no error.
- STALL: hold core_rd_data. Go to IDLE on the first edge with stall=0.
- busy (combinational) = (state==IDLE & core_req & ~flush) | state==REQ | state==ACCESS. busy is 0 in STALL.
- Latency:
  - core_req edge to bus_req_ low: 1 cycle.
  - grant edge to bus_as_ low: 1 cycle.
  - rdy_ edge to core_rd_data valid: 1 cycle.
  - Minimum access with immediate grant and ready: 3 cycles.
- Back-to-back: a new core_req is accepted the edge after returning to IDLE. bus_req_ is high for at least one cycle between accesses, which gives the arbiter a rotation point.

Decomposition:
- Shared bus header: state encodings (BUS_IF_STATE_IDLE/REQ/ACCESS/STALL, 2-bit), BusIfStateBus width macro, READ/WRITE, ENABLE_/DISABLE_ polarity constants.
- Optional sub-module: bus_timeout_cnt (load/clear, increment, terminal-count flag), reusable by the slave-side wait logic.

Test Plan:
- Read, immediate grant, rdy_ one cycle after as_, addr=0x0000_0100, bus_rd_data=0xDEAD_BEEF -> bus_req_ low cycle 1, as_ low cycle 2 only, core_rd_data=0xDEAD_BEEF and busy=0 at cycle 4, bus_req_ high cycle 4.
- Write 0x1234_5678 to 0x0000_0200, grant delayed 5 cycles -> bus_as_ asserted only after grant, bus_rw=0, bus_wr_data=0x1234_5678 stable from cycle 1 to ready, core_rd_data unchanged.
- flush while in REQ with grnt_=1 -> bus_req_ high next cycle, no as_, state IDLE. Repeat with flush and grant on the same edge -> access completes normally.
- stall=1 at ready, held 3 cycles, bus_rd_data changes afterwards -> core_rd_data holds the captured value, busy=0, next core_req accepted only after stall falls.
- TIMEOUT=4, slave never readies -> bus_err=1 for exactly one cycle after 4 ACCESS cycles, core_rd_data=0, bus_req_ released. Ready on the 4th cycle -> no error.
- Synchronous reset asserted in ACCESS -> next edge: bus_req_=1, bus_as_=1, busy=0, bus_err=0, core_rd_data=0.
